// File: rtl/ssg_emb_sd_adc_pkg.sv
// ssg_emb_sd_adc_pkg: shared scheduler state encoding, decimation periods and sample width.
package ssg_emb_sd_adc_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_RUN       = 2'd2
    } state_e;
    localparam int SAMPLE_W = 16;
    localparam int PER_64   = 64;
    localparam int PER_128  = 128;
    localparam int CNT_W    = 7;
endpackage

// File: rtl/ssg_emb_sd_adc_dec_timer.sv
// ssg_emb_sd_adc_dec_timer: decimation period counter, cnr128 strobe and warm-up tracking.
// A rate change is only taken at the wrap and the strobe on which it is taken never captures.
module ssg_emb_sd_adc_dec_timer
    import ssg_emb_sd_adc_pkg::*;
#(
    parameter int WARMUP = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    input  logic sync_i,
    input  logic dec_rate_i,
    output logic cnr_o,
    output logic cap_trig_o
);
    localparam logic [CNT_W-1:0] LAST_64  = CNT_W'(PER_64 - 1);
    localparam logic [CNT_W-1:0] LAST_128 = CNT_W'(PER_128 - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             per_q, per_d;
    logic [7:0]       wup_q, wup_d;
    logic             wrap, chg;
    always_comb begin
        wrap       = run_i && !sync_i && (cnt_q == (per_q ? LAST_64 : LAST_128));
        chg        = wrap && (dec_rate_i != per_q);
        cnr_o      = wrap;
        cap_trig_o = wrap && !chg && (wup_q == 8'd0);
        cnt_d      = (!run_i || sync_i || wrap) ? '0 : cnt_q + 1'b1;
        per_d      = (!run_i || wrap) ? dec_rate_i : per_q;
        wup_d      = (!run_i || sync_i || chg) ? 8'(WARMUP)
                   : (wrap && wup_q != 8'd0) ? wup_q - 8'd1 : wup_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            per_q <= 1'b0;
            wup_q <= 8'(WARMUP);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            wup_q <= wup_d;
        end
    end
endmodule

// File: rtl/ssg_emb_sd_adc_dec_ctrl.sv
// ssg_emb_sd_adc_dec_ctrl: Sinc3 decimator scheduler with delayed capture, hold registers and read port.
// Sticky overrun flags exist only when SSG_EMB_SD_ADC_OVR_EN is defined.
module ssg_emb_sd_adc_dec_ctrl
    import ssg_emb_sd_adc_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int CAP_DLY = 3,
    parameter int WARMUP  = 3
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        enable,
    input  logic                                        dec_rate,
    input  logic                                        sync_in,
    input  logic [SAMPLE_W*NUM_CH-1:0]                  sample_in,
    output logic                                        cnr128,
    input  logic                                        rd_req,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    output logic                                        rd_ack,
    output logic [SAMPLE_W-1:0]                         rd_data,
    output logic [NUM_CH-1:0]                           valid,
    output logic                                        irq,
    output logic [NUM_CH-1:0]                           ovr,
    input  logic                                        ovr_clr
);
    state_e                           state_q, state_d;
    logic                             run, cap_trig, fire, rd_ok;
    logic [2:0]                       dly_q, dly_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold_q, hold_d;
    logic [NUM_CH-1:0]                valid_q, valid_d, rd_mask;
    logic                             rd_ack_q, irq_q;
    logic [SAMPLE_W-1:0]              rd_data_q, rd_data_d;

    assign run = (state_q == ST_RUN);

    ssg_emb_sd_adc_dec_timer #(.WARMUP(WARMUP)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_i      (run),
        .sync_i     (sync_in),
        .dec_rate_i (dec_rate),
        .cnr_o      (cnr128),
        .cap_trig_o (cap_trig)
    );

    // Periods are far longer than CAP_DLY, so a single countdown covers the one pending capture.
    always_comb begin
        state_d   = !enable ? ST_IDLE
                  : (state_q == ST_IDLE) ? ST_SYNC_WAIT
                  : (state_q == ST_SYNC_WAIT && sync_in) ? ST_RUN : state_q;
        fire      = (dly_q == 3'd1) && run && enable && !sync_in;
        dly_d     = (!run || !enable || sync_in) ? 3'd0
                  : cap_trig ? 3'(CAP_DLY - 1)
                  : (dly_q != 3'd0) ? dly_q - 3'd1 : 3'd0;
        rd_ok     = rd_req && (32'(rd_ch) < NUM_CH);
        rd_mask   = rd_ok ? (NUM_CH'(1) << rd_ch) : '0;
        rd_data_d = rd_ok ? hold_q[rd_ch] : '0;
        hold_d    = fire ? sample_in : hold_q;
        valid_d   = fire ? '1 : (valid_q & ~rd_mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            hold_q    <= '0;
            valid_q   <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            rd_ack_q  <= rd_req;
            rd_data_q <= rd_data_d;
            irq_q     <= fire;
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign valid   = valid_q;
    assign irq     = irq_q;

`ifdef SSG_EMB_SD_ADC_OVR_EN
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    // A capture wins over a simultaneous clear so a fresh overrun is never lost.
    assign ovr_d = fire ? (ovr_q | valid_q) : ovr_clr ? '0 : ovr_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovr_q <= '0;
        else          ovr_q <= ovr_d;
    end
    assign ovr = ovr_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign ovr = '0;
`endif
endmodule

// File: doc/ssg_emb_sd_adc_dec_ctrl.md
SSG_EMB_SD_ADC_DEC_CTRL -- requirements
Module: ssg_emb_sd_adc_dec_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of Sinc3 decimator channels sequenced.
REQ-002 Parameter CAP_DLY, default 3: clocks from cnr128 pulse to sample capture, legal range 2..7.
REQ-003 Parameter WARMUP, default 3: decimation periods discarded after (re)start.
REQ-004 clk  in  1  ADC modulator clock; the only clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; high runs the scheduler.
REQ-007 dec_rate  in  1  1: M=64, 0: M=128.
REQ-008 sync_in  in  1  single-cycle phase-alignment pulse.
REQ-009 sample_in  in  16*NUM_CH  decimator outputs, channel 0 in bits [15:0].
REQ-010 cnr128  out  1  decimation strobe to all decimators.
REQ-011 rd_req  in  1  single-cycle read request.
REQ-012 rd_ch  in  clog2(NUM_CH)  channel to read, sampled with rd_req.
REQ-013 rd_ack  out  1  read acknowledge pulse.
REQ-014 rd_data  out  16  read data.
REQ-015 valid  out  NUM_CH  per-channel unread-sample flags.
REQ-016 irq  out  1  capture pulse.
REQ-017 ovr  out  NUM_CH  sticky overrun flags.
REQ-018 ovr_clr  in  1  clears all ovr bits.

Function
REQ-019 States IDLE, SYNC_WAIT, RUN; enable low from any state forces IDLE next cycle.
REQ-020 IDLE: counter 0, cnr128 low, no captures; enable high -> SYNC_WAIT.
REQ-021 SYNC_WAIT: counter held 0; sync_in high -> RUN with counter 0 next cycle.
REQ-022 RUN: counter increments each clock; cnr128 high for exactly one cycle when counter = P-1, counter then wraps to 0; P=64 or 128.
REQ-023 dec_rate sampled only at wrap; the change takes effect on the following period; a change also restarts warm-up.
REQ-024 sync_in in RUN resets counter to 0 next cycle, suppresses any cnr128 in that cycle, restarts warm-up.
REQ-025 Warm-up: first WARMUP cnr128 pulses after entering RUN or restart generate no capture.
REQ-026 Capture: exactly CAP_DLY clocks after each post-warm-up cnr128, all channels latched into hold registers, valid set to all ones, irq high one cycle.
REQ-027 Pending capture is cancelled if state leaves RUN or resync occurs before it fires.
REQ-028 Read: rd_req -> rd_ack and rd_data = hold[rd_ch] next cycle, valid[rd_ch] cleared; rd_ch >= NUM_CH returns 16'h0000 with rd_ack, no flag change.
REQ-029 Read and capture on the same cycle: rd_data returns pre-capture value; valid stays set.
REQ-030 Hold registers and valid retain values across IDLE; not cleared by enable low.

Reset
REQ-031 reset_n low: state IDLE, counter 0, cnr128 0, rd_ack 0, rd_data 0, hold 0, valid 0, irq 0, ovr 0, warm-up count reloaded, pending capture cancelled.
REQ-032 Reset mid-period acts immediately; no partial cnr128 pulse.

Configuration
REQ-033 Macro SSG_EMB_SD_ADC_OVR_EN defined: capture while valid[i]=1 sets ovr[i]; ovr_clr clears all; capture and ovr_clr together leave ovr set.
REQ-034 Macro undefined: ovr tied 0, ovr_clr ignored; all else identical.

Structure
REQ-035 Shared package ssg_emb_sd_adc_pkg holds state encoding, period constants 64/128, sample width 16.
REQ-036 Sub-module ssg_emb_sd_adc_dec_timer holds counter, period select, cnr128 and warm-up count; top holds FSM, capture and read.

Verification
REQ-037 Reset, enable=1, dec_rate=0, sync at t0 -> cnr128 every 128 clocks; first capture CAP_DLY after 4th pulse, irq one cycle.
REQ-038 dec_rate 0->1 mid-period -> current period 128, next 64; next 3 pulses no capture.
REQ-039 sync_in at counter 50 in RUN -> next cnr128 exactly 64/128 clocks later; pending capture cancelled.
REQ-040 sample_in ch1=16'h1234 at capture, rd_req rd_ch=1 -> next cycle rd_ack=1, rd_data=16'h1234, valid[1]=0.
REQ-041 With macro, two captures without read -> ovr=all ones; ovr_clr -> 0; without macro ovr stays 0.
REQ-042 rd_req coincident with capture, old hold 16'h0001, new 16'h0002 -> rd_data 16'h0001, valid stays 1.
